// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation
// encoding, FSM states and default operand width.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = $clog2(XLEN_DEF);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv_unit_core.sv
// Iterative mul/div datapath: shift-add multiply, restoring divide and the
// final sign correction. Sequencing comes from ex_muldiv_unit.
// Optional MULDIV_FAST_MUL_EN: one full-width product step for MULT/MULTU.
module ex_muldiv_unit_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            div0_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [XLEN-1:0]   orig_a_q, orig_a_d;
  logic              res_neg_q, res_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              is_div_q, is_div_d;
  logic              div0_q, div0_d;

  logic              is_signed, is_div_in, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     trial, diff;
`ifndef MULDIV_FAST_MUL_EN
  logic [XLEN:0]     sum;
`endif

  always_comb begin
    acc_d     = acc_q;
    operand_d = operand_q;
    orig_a_d  = orig_a_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    trial     = '0;
    diff      = '0;
`ifndef MULDIV_FAST_MUL_EN
    sum       = '0;
`endif

    is_signed = (op == OP_MULT) || (op == OP_DIV);
    is_div_in = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = is_signed & a[XLEN-1];
    b_neg     = is_signed & b[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;

    if (load) begin
      // Divide: dividend sits in the low half and shifts up into the remainder.
      // Multiply: multiplier sits in the low half and shifts out from the bottom.
      acc_d     = {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
      operand_d = is_div_in ? b_mag : a_mag;
      orig_a_d  = a;
      res_neg_d = a_neg ^ b_neg;
      rem_neg_d = a_neg;
      is_div_d  = is_div_in;
      div0_d    = is_div_in && (b == '0);
    end else if (step) begin
      if (is_div_q) begin
        trial = acc_q[2*XLEN-1:XLEN-1];
        diff  = trial - {1'b0, operand_q};
        if (!diff[XLEN])
          acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
          acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
`ifdef MULDIV_FAST_MUL_EN
        acc_d = {{XLEN{1'b0}}, operand_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
`else
        sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                (acc_q[0] ? {1'b0, operand_q} : {(XLEN+1){1'b0}});
        acc_d = {sum, acc_q[XLEN-1:1]};
`endif
      end
    end
  end

  // NOTE: datapath registers carry no reset; every operation loads them before use.
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    operand_q <= operand_d;
    orig_a_q  <= orig_a_d;
    res_neg_q <= res_neg_d;
    rem_neg_q <= rem_neg_d;
    is_div_q  <= is_div_d;
    div0_q    <= div0_d;
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  always_comb begin
    prod = res_neg_q ? -acc_q : acc_q;
    quot = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    if (div0_q) begin
      hi_o = orig_a_q;
      lo_o = '1;
    end else if (is_div_q) begin
      hi_o = rem_neg_q ? -rem : rem;
      lo_o = res_neg_q ? -quot : quot;
    end else begin
      hi_o = prod[2*XLEN-1:XLEN];
      lo_o = prod[XLEN-1:0];
    end
  end

  assign div0_o = div0_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, iteration counter and HI/LO registers.
// Optional MULDIV_FAST_MUL_EN shortens MULT/MULTU to a single RUN step.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            rd_hilo,
  input  logic            flush,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic            div0
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d;
  logic            div0_q, div0_d;

  logic            accept, mt_wr;
  logic [XLEN-1:0] core_hi, core_lo;
  logic            core_div0;

  ex_muldiv_unit_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .load   (accept),
    .step   (state_q == S_RUN),
    .op     (op),
    .a      (rs_val),
    .b      (rt_val),
    .hi_o   (core_hi),
    .lo_o   (core_lo),
    .div0_o (core_div0)
  );

  // NOTE: every *_d gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    div0_d  = div0_q;

    // Flush wins over start; ops 6-7 match neither decode.
    accept = start && !flush && (state_q == S_IDLE) && !op[2];
    mt_wr  = start && !flush && (state_q == S_IDLE) &&
             ((op == OP_MTHI) || (op == OP_MTLO));

    unique case (state_q)
      S_IDLE: begin
        if (mt_wr) begin
          if (op == OP_MTHI) hi_d = rs_val;
          else               lo_d = rs_val;
          div0_d = 1'b0;
        end
        if (accept) begin
          state_d = S_RUN;
          div0_d  = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
          count_d = ((op == OP_MULT) || (op == OP_MULTU)) ? LAST : '0;
`else
          count_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d   = core_hi;
          lo_d   = core_lo;
          div0_d = core_div0;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignment so each flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = done_q;
  assign div0      = div0_q;
  assign busy      = (state_q != S_IDLE);
  assign stall_req = busy & (start | rd_hilo);

endmodule
